// File: rtl/ysyx_pcgen_if.sv
// Front-end PC request bundle between the next-PC generator (master) and the IFU (slave).
interface ysyx_pcgen_if #(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 3
);
  logic               flush_valid;
  logic [XLEN-1:0]    flush_pc;
  logic               pred_valid;
  logic [XLEN-1:0]    pred_pc;
  logic [EPOCH_W-1:0] pred_epoch;
  logic               pc_ready;
  logic               pc_valid;
  logic [XLEN-1:0]    pc_o;
  logic [3:0]         pc_cnt;
  logic [EPOCH_W-1:0] epoch_o;
  logic               redirect_o;
  logic               misalign_o;

  modport master (
    input  flush_valid, flush_pc, pred_valid, pred_pc, pred_epoch, pc_ready,
    output pc_valid, pc_o, pc_cnt, epoch_o, redirect_o, misalign_o
  );

  modport slave (
    output flush_valid, flush_pc, pred_valid, pred_pc, pred_epoch, pc_ready,
    input  pc_valid, pc_o, pc_cnt, epoch_o, redirect_o, misalign_o
  );
endinterface

// File: rtl/ysyx_pcgen.sv
// Next-PC generator: issues aligned fetch-group PCs, arbitrates flush > prediction > sequential,
// and tags each group with a speculation epoch bumped on every flush.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
`ifndef YSYX_PC_INIT
`define YSYX_PC_INIT 32'h8000_0000
`endif

module ysyx_pcgen #(
  parameter int                XLEN      = `YSYX_W_WIDTH,
  parameter logic [XLEN-1:0]   PC_INIT   = `YSYX_PC_INIT,
  parameter int                FETCH_W   = 2,
  parameter int                EPOCH_W   = 3,
  parameter int                BOOT_HOLD = 2
) (
  input logic clk,
  input logic rst,
  ysyx_pcgen_if.master bus
);
  localparam int G     = FETCH_W * 4;
  localparam int OFF_W = $clog2(FETCH_W);
  localparam int BW    = $clog2(BOOT_HOLD + 1);
  localparam logic [XLEN-1:0] GMASK = ~(XLEN'(G - 1));

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_BUBBLE} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redir_q, redir_d;
  logic               mis_q, mis_d;
  logic               pend_vld_q, pend_vld_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic [BW-1:0]      boot_cnt_q, boot_cnt_d;

  logic fire, pred_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= PC_INIT;
      epoch_q    <= '0;
      redir_q    <= 1'b1;
      mis_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      boot_cnt_q <= BW'(BOOT_HOLD);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      redir_q    <= redir_d;
      mis_q      <= mis_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    redir_d    = 1'b0;
    mis_d      = mis_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    boot_cnt_d = boot_cnt_q;

    fire    = (state_q == S_RUN) && bus.pc_ready;
    // A flush in the same cycle makes the prediction stale, so it never counts.
    pred_ok = bus.pred_valid && (bus.pred_epoch == epoch_q) && !bus.flush_valid;

    case (state_q)
      S_BOOT: begin
        boot_cnt_d = (boot_cnt_q == '0) ? '0 : boot_cnt_q - BW'(1);
        if (boot_cnt_q <= BW'(1)) state_d = S_RUN;
      end
      S_BUBBLE: state_d = S_RUN;
      default:  state_d = state_q;
    endcase

    if (bus.flush_valid) begin
      pc_d       = {bus.flush_pc[XLEN-1:2], 2'b00};
      epoch_d    = epoch_q + EPOCH_W'(1);
      pend_vld_d = 1'b0;
      redir_d    = 1'b1;
      if (bus.flush_pc[1:0] != 2'b00) mis_d = 1'b1;
      // Boot keeps counting down; otherwise insert (or restart) the one-cycle bubble.
      state_d    = (state_q == S_BOOT) ? S_BOOT : S_BUBBLE;
    end else begin
      if (pred_ok && bus.pred_pc[1:0] != 2'b00) mis_d = 1'b1;
      if (fire) begin
        pend_vld_d = 1'b0;
        if (pred_ok)         pc_d = {bus.pred_pc[XLEN-1:2], 2'b00};
        else if (pend_vld_q) pc_d = pend_pc_q;
        else                 pc_d = (pc_q & GMASK) + XLEN'(G);
      end else if (pred_ok) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = {bus.pred_pc[XLEN-1:2], 2'b00};
      end
    end
  end

  generate
    if (OFF_W == 0) begin : g_cnt1
      assign bus.pc_cnt = 4'd1;
    end else begin : g_cntn
      // Entering mid-group shortens the group to the remaining slots.
      logic [OFF_W-1:0] off;
      assign off        = pc_q[OFF_W+1:2];
      assign bus.pc_cnt = 4'(FETCH_W) - 4'(off);
    end
  endgenerate

  assign bus.pc_valid   = (state_q == S_RUN);
  assign bus.pc_o       = pc_q;
  assign bus.epoch_o    = epoch_q;
  assign bus.redirect_o = redir_q;
  assign bus.misalign_o = mis_q;
endmodule
